gray_stream_arbiter: RTL and testbench
======================================

// Module: gray_stream_arbiter
// PURPOSE
//  Shares one rgb2gray pipeline between NumReq independent RGB pixel streams.
//  - Arbitrates the streams round-robin onto the pipeline input.
//  - Records a requester tag for every accepted pixel.
//  - Routes each gray result back to the requester that issued it, in issue order.
//  - Sits between the camera/DMA pixel sources and the single rgb2gray instance.
// PARAMETERS
//  DataWidth    8  bits per colour channel and per gray output
//  NumReq       4  number of requester streams (2..8)
//  MaxInflight  8  tag FIFO depth = max pixels inside rgb2gray; power of 2
// PORTS
//  clk_i          in   1                   clock
//  reset_ni       in   1                   synchronous, active-low reset
//  req_valid_i    in   NumReq              per-requester pixel valid
//  req_red_i      in   NumReq*DataWidth    packed channels; requester i at [i*DataWidth +: DataWidth]
//  req_green_i    in   NumReq*DataWidth    as above
//  req_blue_i     in   NumReq*DataWidth    as above
//  req_ready_o    out  NumReq              per-requester pixel accepted
//  pix_valid_o    out  1                   to rgb2gray valid_i
//  pix_red_o      out  DataWidth           to rgb2gray red_i
//  pix_green_o    out  DataWidth           to rgb2gray green_i
//  pix_blue_o     out  DataWidth           to rgb2gray blue_i
//  pix_ready_i    in   1                   from rgb2gray ready_o
//  gray_valid_i   in   1                   from rgb2gray valid_o
//  gray_i         in   DataWidth           from rgb2gray gray_o
//  gray_ready_o   out  1                   to rgb2gray ready_i
//  res_valid_o    out  NumReq              per-requester gray valid
//  res_gray_o     out  DataWidth           gray value, shared bus; qualified by res_valid_o
//  res_ready_i    in   NumReq              per-requester gray ready
// BEHAVIOUR
//  Reset (reset_ni=0 at clk_i edge):
//   - Outputs low: req_ready_o, pix_valid_o, gray_ready_o, res_valid_o.
//   - State cleared: RR pointer=0, tag FIFO empty, grant lock cleared.
//  Reset mid-operation:
//   - Flushes all tags; results for pixels issued before reset are never routed.
//   - rgb2gray shares this reset, so no stale results remain in the pipeline.
//  Issue side, state IDLE/HOLD:
//   - IDLE: grant = first asserted req_valid_i at or after the RR pointer, wrapping NumReq-1 -> 0.
//   - pix_valid_o = |req_valid_i & !tag_full.
//   - pix_* is muxed from the granted requester.
//   - Stall (pix_valid_o & !pix_ready_i): register the grant and go to HOLD.
//   - HOLD: the grant and pix_* stay stable until the transfer completes; the pixel is never re-arbitrated.
//   - req_ready_o[g] = pix_ready_i & pix_valid_o & grant==g; all other bits are 0.
//  Transfer (pix_valid_o & pix_ready_i):
//   - Push tag g, with combinational issue (zero added latency).
//   - RR pointer <= g+1 mod NumReq; return to IDLE.
//  tag_full:
//   - Blocks issue even when a pop occurs in the same cycle, so MaxInflight is never exceeded.
//  Return side:
//   - head = oldest tag.
//   - gray_ready_o = !tag_empty & res_ready_i[head].
//   - res_valid_o[head] = gray_valid_i & !tag_empty; res_gray_o = gray_i.
//   - Pop on gray_valid_i & gray_ready_o.
//   - gray_valid_i while tag_empty is a protocol error: ignored and never routed (assertion fires).
//  Ordering: simultaneous push and pop are allowed when not full; results for one requester stay in issue order.
//  Throughput: 1 pixel/cycle sustained when rgb2gray and all sinks are always ready.
// CONFIGURATION
//  GRAY_ARB_LINE_LOCK_EN defined:
//   - Adds port req_last_i [NumReq].
//   - A grant is held across cycles until a transfer with req_last_i[g]=1; a whole line issues contiguously.
//   - The RR pointer advances only on last.
//  GRAY_ARB_LINE_LOCK_EN undefined: per-pixel round-robin as above; no req_last_i port.
// STRUCTURE
//  Package gray_arb_pkg:
//   - typedef rgb_t {red, green, blue}.
//   - typedef tag_t = logic [$clog2(NumReq)-1:0].
//   - localparam MaxNumReq = 8.
//  Sub-module gray_tag_fifo: synchronous FIFO of tag_t, depth MaxInflight, with full/empty outputs.
//  Top: RR arbiter, grant-hold FSM, output mux and demux.
// TESTING
//  1. Only req 2 valid, rgb=(255,255,255), pipeline always ready -> issues every cycle; res_valid_o[2] only, gray=255.
//  2. All 4 valid continuously -> grant order 0,1,2,3,0,...; each requester receives its own gray, in issue order.
//  3. pix_ready_i=0 for 3 cycles while req1 granted, then req0 asserts valid -> grant and pix_* stay at req1 until accepted.
//  4. res_ready_i[head]=0 with MaxInflight=8 pixels issued -> gray_ready_o=0, issue stops at 8; release -> drains in order.
//  5. reset_ni=0 for 1 cycle with 5 in flight -> all outputs 0 next cycle, FIFO empty, pointer restarts at 0.
//  6. (LINE_LOCK_EN) req0 sends 4 pixels, last on the 4th, req1 valid throughout -> req1 is granted only after req0's 4th pixel.

Source files
------------

// File: rtl/gray_stream_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gray_arb_pkg                                                         |
// | Shared types and constants for the gray_stream_arbiter slice.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package gray_arb_pkg;

  localparam int c_max_num_req = 8;
  localparam int c_data_width  = 8;

  typedef logic [$clog2(c_max_num_req)-1:0] tag_t;

  typedef struct packed {
    logic [c_data_width-1:0] red;
    logic [c_data_width-1:0] green;
    logic [c_data_width-1:0] blue;
  } rgb_t;

  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_hold = 1'b1;

  function automatic tag_t rr_next(input tag_t g, input int n);
    if (int'(g) >= n - 1) return '0;
    return g + tag_t'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/gray_stream_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gray_stream_arbiter_if                                               |
// | Requester, rgb2gray and result buses; req_last_i only exists when    |
// | GRAY_ARB_LINE_LOCK_EN is defined.                                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface gray_stream_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
);
  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_red_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_green_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_blue_i;
  logic [NUM_REQ-1:0]            req_ready_o;
`ifdef GRAY_ARB_LINE_LOCK_EN
  logic [NUM_REQ-1:0]            req_last_i;
`endif
  logic                          pix_valid_o;
  logic [DATA_WIDTH-1:0]         pix_red_o;
  logic [DATA_WIDTH-1:0]         pix_green_o;
  logic [DATA_WIDTH-1:0]         pix_blue_o;
  logic                          pix_ready_i;
  logic                          gray_valid_i;
  logic [DATA_WIDTH-1:0]         gray_i;
  logic                          gray_ready_o;
  logic [NUM_REQ-1:0]            res_valid_o;
  logic [DATA_WIDTH-1:0]         res_gray_o;
  logic [NUM_REQ-1:0]            res_ready_i;

  modport slave (
    input  req_valid_i, req_red_i, req_green_i, req_blue_i,
`ifdef GRAY_ARB_LINE_LOCK_EN
    input  req_last_i,
`endif
    output req_ready_o,
    output pix_valid_o, pix_red_o, pix_green_o, pix_blue_o,
    input  pix_ready_i, gray_valid_i, gray_i,
    output gray_ready_o, res_valid_o, res_gray_o,
    input  res_ready_i
  );

  modport master (
    output req_valid_i, req_red_i, req_green_i, req_blue_i,
`ifdef GRAY_ARB_LINE_LOCK_EN
    output req_last_i,
`endif
    input  req_ready_o,
    input  pix_valid_o, pix_red_o, pix_green_o, pix_blue_o,
    output pix_ready_i, gray_valid_i, gray_i,
    input  gray_ready_o, res_valid_o, res_gray_o,
    output res_ready_i
  );
endinterface
`default_nettype wire

// File: rtl/gray_stream_arbiter_tag_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gray_tag_fifo                                                        |
// | Synchronous FIFO of requester tags for pixels inside rgb2gray.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module gray_tag_fifo
  import gray_arb_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  wire logic clk_i,
  input  wire logic reset_ni,
  input  wire logic i_push,
  input  wire tag_t i_tag,
  input  wire logic i_pop,
  output tag_t      o_head,
  output logic      o_full,
  output logic      o_empty
);
  localparam int c_aw = $clog2(DEPTH);

  tag_t            r_mem [DEPTH];
  logic [c_aw:0]   r_wr_ptr;
  logic [c_aw:0]   r_rd_ptr;
  logic            w_wr;
  logic            w_rd;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                   (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign w_wr    = i_push && !o_full;
  assign w_rd    = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr[c_aw-1:0]];

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + (c_aw+1)'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + (c_aw+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wr_ptr[c_aw-1:0]] <= i_tag;
  end

endmodule
`default_nettype wire

// File: rtl/gray_stream_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gray_stream_arbiter                                                  |
// | Round-robin sharing of one rgb2gray pipeline between NUM_REQ streams,|
// | tag-based routing of results. Option: GRAY_ARB_LINE_LOCK_EN.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module gray_stream_arbiter
  import gray_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_REQ      = 4,
  parameter int MAX_INFLIGHT = 8
) (
  input wire logic              clk_i,
  input wire logic              reset_ni,
  gray_stream_arbiter_if.slave  bus
);
  logic [0:0]                  r_state;
  logic [0:0]                  w_state_nxt;
  tag_t                        r_grant;
  tag_t                        r_rr_ptr;
  tag_t                        w_rr_nxt;
  tag_t                        w_arb_grant;
  tag_t                        w_grant;
  tag_t                        w_head;
  logic                        w_any;
  logic                        w_pix_valid;
  logic                        w_xfer;
  logic                        w_last;
  logic                        w_full;
  logic                        w_empty;
  logic                        w_gray_ready;
  logic                        w_pop;
  logic [c_max_num_req-1:0]    w_req_valid;
  logic [c_max_num_req-1:0]    w_res_ready;
  logic [DATA_WIDTH-1:0]       w_red   [c_max_num_req];
  logic [DATA_WIDTH-1:0]       w_green [c_max_num_req];
  logic [DATA_WIDTH-1:0]       w_blue  [c_max_num_req];

  // Per-requester vectors are padded to the tag range so a tag indexes them exactly.
  assign w_req_valid = c_max_num_req'(bus.req_valid_i);
  assign w_res_ready = c_max_num_req'(bus.res_ready_i);

  for (genvar gi = 0; gi < c_max_num_req; gi++) begin : g_chan
    if (gi < NUM_REQ) begin : g_used
      assign w_red[gi]   = bus.req_red_i  [gi*DATA_WIDTH +: DATA_WIDTH];
      assign w_green[gi] = bus.req_green_i[gi*DATA_WIDTH +: DATA_WIDTH];
      assign w_blue[gi]  = bus.req_blue_i [gi*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_pad
      assign w_red[gi]   = '0;
      assign w_green[gi] = '0;
      assign w_blue[gi]  = '0;
    end
  end

`ifdef GRAY_ARB_LINE_LOCK_EN
  logic [c_max_num_req-1:0] w_req_last;
  assign w_req_last = c_max_num_req'(bus.req_last_i);
  assign w_last     = w_req_last[w_grant];
`else
  assign w_last = 1'b1;
`endif

  // Lowest offset from the pointer wins; iterate downwards so it is assigned last.
  always_comb begin
    w_arb_grant = r_rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_req_valid[tag_t'((int'(r_rr_ptr) + k) % NUM_REQ)])
        w_arb_grant = tag_t'((int'(r_rr_ptr) + k) % NUM_REQ);
    end
  end

  assign w_grant     = (r_state == c_st_hold) ? r_grant : w_arb_grant;
  assign w_any       = (r_state == c_st_hold) ? w_req_valid[r_grant] : |bus.req_valid_i;
  assign w_pix_valid = reset_ni && w_any && !w_full;
  assign w_xfer      = w_pix_valid && bus.pix_ready_i;
  assign w_gray_ready = reset_ni && !w_empty && w_res_ready[w_head];
  assign w_pop       = bus.gray_valid_i && w_gray_ready;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      r_state  <= c_st_idle;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant;
      r_rr_ptr <= w_rr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_ptr;
    case (r_state)
      c_st_idle: if (w_pix_valid && (!bus.pix_ready_i || !w_last)) w_state_nxt = c_st_hold;
      c_st_hold: if (w_xfer && w_last) w_state_nxt = c_st_idle;
      default:   w_state_nxt = c_st_idle;
    endcase
    if (w_xfer && w_last) w_rr_nxt = rr_next(w_grant, NUM_REQ);
  end

  always_comb begin
    bus.pix_valid_o  = w_pix_valid;
    bus.pix_red_o    = w_red[w_grant];
    bus.pix_green_o  = w_green[w_grant];
    bus.pix_blue_o   = w_blue[w_grant];
    bus.gray_ready_o = w_gray_ready;
    bus.res_gray_o   = bus.gray_i;
    bus.req_ready_o  = '0;
    bus.res_valid_o  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_ready_o[i] = w_xfer && (w_grant == tag_t'(i));
      bus.res_valid_o[i] = reset_ni && bus.gray_valid_i && !w_empty && (w_head == tag_t'(i));
    end
  end

  gray_tag_fifo #(.DEPTH(MAX_INFLIGHT)) u_tag_fifo (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .i_push   (w_xfer),
    .i_tag    (w_grant),
    .i_pop    (w_pop),
    .o_head   (w_head),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  a_no_orphan_result: assert property (@(posedge clk_i) disable iff (!reset_ni)
    !(bus.gray_valid_i && w_empty));

endmodule
`default_nettype wire

// File: tb/tb_gray_stream_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_gray_stream_arbiter                                               |
// | Directed bench: requester sources, luma pipeline model, result log.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_gray_stream_arbiter;
  import gray_arb_pkg::*;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int MI = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  gray_stream_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  gray_stream_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_INFLIGHT(MI)) dut (
    .clk_i    (clk),
    .reset_ni (reset_n),
    .bus      (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [NR-1:0] src_en = '0;
  int            limit [NR];
  int            sent  [NR];
  bit            force_white = 1'b0;
  bit            line_mode = 1'b0;
  bit            pipe_en = 1'b1;
  logic          pix_ready = 1'b1;
  logic [NR-1:0] res_ready = '1;
  logic          gv = 1'b0;
  logic [7:0]    gd = '0;
  logic [7:0]    pipe_q [$];
  logic [15:0]   res_log [$];

  function automatic logic [7:0] code(input int i, input int s);
    return 8'(i * 64 + s);
  endfunction

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      bus.req_valid_i[i]             = src_en[i] && (sent[i] < limit[i]);
      bus.req_red_i[i*DW +: DW]      = force_white ? 8'hFF : code(i, sent[i]);
      bus.req_green_i[i*DW +: DW]    = force_white ? 8'hFF : code(i, sent[i]);
      bus.req_blue_i[i*DW +: DW]     = force_white ? 8'hFF : code(i, sent[i]);
`ifdef GRAY_ARB_LINE_LOCK_EN
      bus.req_last_i[i]              = line_mode ? (sent[i] == limit[i] - 1) : 1'b1;
`endif
    end
  end

  assign bus.pix_ready_i  = pix_ready;
  assign bus.res_ready_i  = res_ready;
  assign bus.gray_valid_i = gv;
  assign bus.gray_i       = gd;

  // Source bookkeeping and rgb2gray model: sample at posedge, drive at negedge.
  initial begin
    logic [NR-1:0] acc;
    bit            rst_seen;
    rgb_t          px;
    int            y;
    forever begin
      @(posedge clk);
      rst_seen = !reset_n;
      acc = bus.req_ready_o;
      if (bus.gray_valid_i && bus.gray_ready_o) void'(pipe_q.pop_front());
      if (bus.pix_valid_o && bus.pix_ready_i) begin
        px.red = bus.pix_red_o; px.green = bus.pix_green_o; px.blue = bus.pix_blue_o;
        y = (77 * int'(px.red) + 150 * int'(px.green) + 29 * int'(px.blue)) >> 8;
        pipe_q.push_back(8'(y));
      end
      for (int i = 0; i < NR; i++)
        if (bus.res_valid_o[i] && bus.res_ready_i[i]) res_log.push_back({8'(i), bus.res_gray_o});
      @(negedge clk);
      if (rst_seen) begin
        for (int i = 0; i < NR; i++) sent[i] = 0;
        pipe_q.delete();
      end else begin
        for (int i = 0; i < NR; i++) if (acc[i]) sent[i] = sent[i] + 1;
      end
      gv = pipe_en && (pipe_q.size() > 0);
      gd = (pipe_q.size() > 0) ? pipe_q[0] : 8'h00;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input int n);
    reset_n = 1'b0; src_en = '0; force_white = 1'b0; line_mode = 1'b0;
    pipe_en = 1'b1; pix_ready = 1'b1; res_ready = '1;
    for (int i = 0; i < NR; i++) limit[i] = 0;
    repeat (n) @(negedge clk);
    reset_n = 1'b1;
    res_log.delete();
  endtask

  task automatic wait_results(input int n);
    for (int t = 0; t < 60 && res_log.size() < n; t++) @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; limit[0] = 1; src_en = 4'b0001;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.pix_valid_o !== 1'b0) begin failures++; $display("FAIL reset_pix_valid: got %b, expected 0", bus.pix_valid_o); end
    checks++;
    if (bus.req_ready_o !== 4'b0000) begin failures++; $display("FAIL reset_req_ready: got %b, expected 0000", bus.req_ready_o); end
    checks++;
    if (bus.gray_ready_o !== 1'b0) begin failures++; $display("FAIL reset_gray_ready: got %b, expected 0", bus.gray_ready_o); end
    checks++;
    if (bus.res_valid_o !== 4'b0000) begin failures++; $display("FAIL reset_res_valid: got %b, expected 0000", bus.res_valid_o); end
    src_en = '0; reset_n = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (bus.pix_valid_o !== 1'b0 || bus.gray_ready_o !== 1'b0) begin
      failures++; $display("FAIL reset_idle: got pix_valid=%b gray_ready=%b, expected 0 0", bus.pix_valid_o, bus.gray_ready_o);
    end
  endtask

  task automatic test_single;
    do_reset(2);
    force_white = 1'b1; limit[2] = 6; src_en = 4'b0100;
    #1;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (bus.pix_valid_o !== 1'b1 || bus.req_ready_o !== 4'b0100 || bus.pix_red_o !== 8'hFF) begin
        failures++;
        $display("FAIL single_issue c%0d: got valid=%b ready=%b red=%h, expected 1 0100 ff",
                 k, bus.pix_valid_o, bus.req_ready_o, bus.pix_red_o);
      end
      @(negedge clk); #1;
    end
    checks++;
    if (bus.pix_valid_o !== 1'b0) begin failures++; $display("FAIL single_done: got pix_valid=%b, expected 0", bus.pix_valid_o); end
    wait_results(6);
    checks++;
    if (res_log.size() != 6) begin failures++; $display("FAIL single_count: got %0d results, expected 6", res_log.size()); end
    foreach (res_log[k]) begin
      checks++;
      if (res_log[k] !== {8'd2, 8'hFF}) begin failures++; $display("FAIL single_result %0d: got %h, expected 02ff", k, res_log[k]); end
    end
  endtask

  task automatic test_round_robin;
    int cnt [NR];
    do_reset(2);
    for (int i = 0; i < NR; i++) begin limit[i] = 3; cnt[i] = 0; end
    src_en = '1;
    #1;
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (bus.req_ready_o !== 4'(1 << (k % 4))) begin
        failures++; $display("FAIL rr_grant c%0d: got %b, expected %b", k, bus.req_ready_o, 4'(1 << (k % 4)));
      end
      @(negedge clk); #1;
    end
    wait_results(12);
    checks++;
    if (res_log.size() != 12) begin failures++; $display("FAIL rr_count: got %0d results, expected 12", res_log.size()); end
    foreach (res_log[k]) begin
      int id;
      id = int'(res_log[k][15:8]) % NR;
      checks++;
      if (res_log[k][7:0] !== code(id, cnt[id])) begin
        failures++; $display("FAIL rr_route %0d: got req%0d gray %h, expected %h", k, id, res_log[k][7:0], code(id, cnt[id]));
      end
      cnt[id]++;
    end
  endtask

  task automatic test_stall;
    do_reset(2);
    pix_ready = 1'b0; limit[0] = 1; limit[1] = 1; src_en = 4'b0010;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.pix_valid_o !== 1'b1 || bus.req_ready_o !== 4'b0000 || bus.pix_red_o !== code(1, 0)) begin
        failures++; $display("FAIL stall_hold c%0d: got valid=%b ready=%b red=%h, expected 1 0000 %h",
                             k, bus.pix_valid_o, bus.req_ready_o, bus.pix_red_o, code(1, 0));
      end
      @(negedge clk);
      src_en = 4'b0011;
      #1;
    end
    pix_ready = 1'b1; #1;
    checks++;
    if (bus.req_ready_o !== 4'b0010 || bus.pix_red_o !== code(1, 0)) begin
      failures++; $display("FAIL stall_release: got ready=%b red=%h, expected 0010 %h", bus.req_ready_o, bus.pix_red_o, code(1, 0));
    end
    @(negedge clk); #1;
    checks++;
    if (bus.req_ready_o !== 4'b0001 || bus.pix_red_o !== code(0, 0)) begin
      failures++; $display("FAIL stall_next: got ready=%b red=%h, expected 0001 %h", bus.req_ready_o, bus.pix_red_o, code(0, 0));
    end
    wait_results(2);
    checks++;
    if (res_log.size() != 2 || res_log[0] !== {8'd1, code(1, 0)} || res_log[1] !== {8'd0, code(0, 0)}) begin
      failures++; $display("FAIL stall_results: got %0d results, expected req1 then req0", res_log.size());
    end
  endtask

  task automatic test_backpressure;
    do_reset(2);
    res_ready = '0; limit[0] = 10; src_en = 4'b0001;
    repeat (12) @(negedge clk);
    #1;
    checks++;
    if (sent[0] != MI) begin failures++; $display("FAIL bp_issued: got %0d, expected %0d", sent[0], MI); end
    checks++;
    if (bus.pix_valid_o !== 1'b0 || bus.gray_ready_o !== 1'b0) begin
      failures++; $display("FAIL bp_full: got pix_valid=%b gray_ready=%b, expected 0 0", bus.pix_valid_o, bus.gray_ready_o);
    end
    checks++;
    if (bus.res_valid_o !== 4'b0001) begin failures++; $display("FAIL bp_res_valid: got %b, expected 0001", bus.res_valid_o); end
    res_ready = '1; #1;
    checks++;
    if (bus.gray_ready_o !== 1'b1 || bus.pix_valid_o !== 1'b0) begin
      failures++; $display("FAIL bp_full_pop: got gray_ready=%b pix_valid=%b, expected 1 0", bus.gray_ready_o, bus.pix_valid_o);
    end
    wait_results(10);
    checks++;
    if (res_log.size() != 10) begin failures++; $display("FAIL bp_count: got %0d results, expected 10", res_log.size()); end
    foreach (res_log[k]) begin
      checks++;
      if (res_log[k] !== {8'd0, code(0, k)}) begin failures++; $display("FAIL bp_order %0d: got %h, expected %h", k, res_log[k], {8'd0, code(0, k)}); end
    end
  endtask

  task automatic test_reset_midflight;
    do_reset(2);
    pipe_en = 1'b0; limit[1] = 5; src_en = 4'b0010;
    for (int t = 0; t < 20 && sent[1] < 5; t++) @(negedge clk);
    #1;
    checks++;
    if (sent[1] != 5) begin failures++; $display("FAIL mid_issue: got %0d issued, expected 5", sent[1]); end
    reset_n = 1'b0; src_en = '0;
    @(negedge clk);
    reset_n = 1'b1; #1;
    checks++;
    if (bus.pix_valid_o !== 1'b0 || bus.req_ready_o !== 4'b0000 || bus.res_valid_o !== 4'b0000 || bus.gray_ready_o !== 1'b0) begin
      failures++; $display("FAIL mid_outputs: got pv=%b rr=%b rv=%b gr=%b, expected all 0",
                           bus.pix_valid_o, bus.req_ready_o, bus.res_valid_o, bus.gray_ready_o);
    end
    pipe_en = 1'b1;
    for (int i = 0; i < NR; i++) limit[i] = 1;
    src_en = '1; #1;
    checks++;
    if (bus.req_ready_o !== 4'b0001) begin failures++; $display("FAIL mid_pointer: got %b, expected 0001", bus.req_ready_o); end
    wait_results(4);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (res_log.size() != 4) begin failures++; $display("FAIL mid_count: got %0d results, expected 4", res_log.size()); end
    foreach (res_log[k]) begin
      checks++;
      if (res_log[k] !== {8'(k), code(k, 0)}) begin failures++; $display("FAIL mid_result %0d: got %h, expected %h", k, res_log[k], {8'(k), code(k, 0)}); end
    end
  endtask

`ifdef GRAY_ARB_LINE_LOCK_EN
  task automatic test_line_lock;
    logic [3:0] exp_seq [6];
    exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010};
    do_reset(2);
    line_mode = 1'b1; limit[0] = 4; limit[1] = 2; src_en = 4'b0011;
    #1;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (bus.req_ready_o !== exp_seq[k]) begin failures++; $display("FAIL line_grant c%0d: got %b, expected %b", k, bus.req_ready_o, exp_seq[k]); end
      @(negedge clk); #1;
    end
    checks++;
    if (bus.pix_valid_o !== 1'b0) begin failures++; $display("FAIL line_done: got pix_valid=%b, expected 0", bus.pix_valid_o); end
  endtask
`endif

  initial begin
    for (int i = 0; i < NR; i++) begin limit[i] = 0; sent[i] = 0; end
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_backpressure();
    test_reset_midflight();
`ifdef GRAY_ARB_LINE_LOCK_EN
    test_line_lock();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
